// File: rtl/mem_agu_multilane_pkg.sv
// Shared types for the multi-lane MEM address-generation unit: widths, funct3 encoding,
// the buffered entry format and the byte-lane helper functions.
package mem_agu_multilane_pkg;
  localparam int BRU_BITS = 2;
  localparam int BR_IDX_W = (BRU_BITS > 1) ? $clog2(BRU_BITS) : 1;
  localparam int ROB_W    = 5;
  localparam int LSQ_W    = 3;
  localparam int PREG_W   = 6;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } load_store_f3_t;

  typedef struct packed {
    logic                valid;
    logic [31:0]         ps1;
    logic [31:0]         ps2;
    logic [31:0]         imm;
    load_store_f3_t      f3;
    logic                is_str;
    logic [ROB_W-1:0]    rob_idx;
    logic [LSQ_W-1:0]    lsq_idx;
    logic [4:0]          rd;
    logic [PREG_W-1:0]   pd;
    logic [BRU_BITS-1:0] br_mask;
  } agu_entry_t;

  // Sub-word masks shift into place and drop bits past byte 3; words always enable all bytes.
  function automatic logic [3:0] agu_wmask(input load_store_f3_t f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << a;
      F3_H, F3_HU: return 4'b0011 << a;
      F3_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] agu_str_val(input load_store_f3_t f3, input logic [31:0] v);
    case (f3)
      F3_B, F3_BU: return {4{v[7:0]}};
      F3_H, F3_HU: return {2{v[15:0]}};
      default:     return v;
    endcase
  endfunction

  function automatic logic agu_misalign(input load_store_f3_t f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return |a;
      default:     return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mem_agu_multilane_if.sv
// Issue-port, branch-resolution and LSQ-side bundle; master is the RS/LSQ side, slave the AGU.
interface mem_agu_multilane_if #(parameter int NUM_LANES = 2);
  import mem_agu_multilane_pkg::*;

  logic [NUM_LANES-1:0]               iss_valid;
  logic [NUM_LANES-1:0]               iss_ready;
  logic [NUM_LANES-1:0][31:0]         iss_ps1_v;
  logic [NUM_LANES-1:0][31:0]         iss_ps2_v;
  logic [NUM_LANES-1:0][31:0]         iss_imm;
  logic [NUM_LANES-1:0][2:0]          iss_f3;
  logic [NUM_LANES-1:0]               iss_is_str;
  logic [NUM_LANES-1:0][ROB_W-1:0]    iss_rob_idx;
  logic [NUM_LANES-1:0][LSQ_W-1:0]    iss_lsq_idx;
  logic [NUM_LANES-1:0][4:0]          iss_rd;
  logic [NUM_LANES-1:0][PREG_W-1:0]   iss_pd;
  logic [NUM_LANES-1:0][BRU_BITS-1:0] iss_br_mask;

  logic                               br_valid;
  logic                               br_mispred;
  logic [BR_IDX_W-1:0]                br_idx;

  logic [NUM_LANES-1:0]               lsq_valid;
  logic [NUM_LANES-1:0]               lsq_ready;
  logic [NUM_LANES-1:0][31:0]         lsq_addr;
  logic [NUM_LANES-1:0][3:0]          lsq_wmask;
  logic [NUM_LANES-1:0][31:0]         lsq_str_val;
  logic [NUM_LANES-1:0]               lsq_misalign;
  logic [NUM_LANES-1:0][2:0]          lsq_f3;
  logic [NUM_LANES-1:0]               lsq_is_str;
  logic [NUM_LANES-1:0][ROB_W-1:0]    lsq_rob_idx;
  logic [NUM_LANES-1:0][LSQ_W-1:0]    lsq_lsq_idx;
  logic [NUM_LANES-1:0][4:0]          lsq_rd;
  logic [NUM_LANES-1:0][PREG_W-1:0]   lsq_pd;
  logic [NUM_LANES-1:0][BRU_BITS-1:0] lsq_br_mask;

  modport master (
    output iss_valid, iss_ps1_v, iss_ps2_v, iss_imm, iss_f3, iss_is_str, iss_rob_idx,
           iss_lsq_idx, iss_rd, iss_pd, iss_br_mask, br_valid, br_mispred, br_idx, lsq_ready,
    input  iss_ready, lsq_valid, lsq_addr, lsq_wmask, lsq_str_val, lsq_misalign, lsq_f3,
           lsq_is_str, lsq_rob_idx, lsq_lsq_idx, lsq_rd, lsq_pd, lsq_br_mask
  );

  modport slave (
    input  iss_valid, iss_ps1_v, iss_ps2_v, iss_imm, iss_f3, iss_is_str, iss_rob_idx,
           iss_lsq_idx, iss_rd, iss_pd, iss_br_mask, br_valid, br_mispred, br_idx, lsq_ready,
    output iss_ready, lsq_valid, lsq_addr, lsq_wmask, lsq_str_val, lsq_misalign, lsq_f3,
           lsq_is_str, lsq_rob_idx, lsq_lsq_idx, lsq_rd, lsq_pd, lsq_br_mask
  );
endinterface

// File: rtl/mem_agu_multilane_lane.sv
// One AGU lane: DEPTH-entry FIFO with in-place squash/mask-clear, and address/byte-lane
// formation on the head entry.
module mem_agu_multilane_lane
  import mem_agu_multilane_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  agu_entry_t          iss_ent,
  input  logic                br_valid,
  input  logic                br_mispred,
  input  logic [BR_IDX_W-1:0] br_idx,
  output logic                lsq_valid,
  input  logic                lsq_ready,
  output logic [31:0]         lsq_addr,
  output logic [3:0]          lsq_wmask,
  output logic [31:0]         lsq_str_val,
  output logic                lsq_misalign,
  output logic [2:0]          lsq_f3,
  output logic                lsq_is_str,
  output logic [ROB_W-1:0]    lsq_rob_idx,
  output logic [LSQ_W-1:0]    lsq_lsq_idx,
  output logic [4:0]          lsq_rd,
  output logic [PREG_W-1:0]   lsq_pd,
  output logic [BRU_BITS-1:0] lsq_br_mask
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  agu_entry_t       ent_q [DEPTH];
  agu_entry_t       ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  agu_entry_t       in_ent, head_ent;
  logic             kill, clr, push, pop, not_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    kill = br_valid & br_mispred;
    clr  = br_valid & ~br_mispred;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (kill && ent_q[i].br_mask[br_idx]) ent_d[i].valid = 1'b0;
      if (clr) ent_d[i].br_mask[br_idx] = 1'b0;
    end
    in_ent       = iss_ent;
    in_ent.valid = iss_ent.valid & ~(kill & iss_ent.br_mask[br_idx]);
    if (clr) in_ent.br_mask[br_idx] = 1'b0;

    // Head is viewed after this cycle's squash/clear so a killed head is never presented.
    head_ent  = ent_d[head_q];
    not_empty = (cnt_q != '0);
    iss_ready = (cnt_q < CNT_W'(DEPTH));
    lsq_valid = not_empty & head_ent.valid;
    pop       = not_empty & (~head_ent.valid | lsq_ready);
    push      = iss_valid & iss_ready & in_ent.valid;

    if (pop)  ent_d[head_q].valid = 1'b0;
    if (push) ent_d[tail_q] = in_ent;
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    lsq_addr     = head_ent.ps1 + head_ent.imm;
    lsq_wmask    = agu_wmask(head_ent.f3, lsq_addr[1:0]);
    lsq_str_val  = agu_str_val(head_ent.f3, head_ent.ps2);
    lsq_misalign = agu_misalign(head_ent.f3, lsq_addr[1:0]);
    lsq_f3       = head_ent.f3;
    lsq_is_str   = head_ent.is_str;
    lsq_rob_idx  = head_ent.rob_idx;
    lsq_lsq_idx  = head_ent.lsq_idx;
    lsq_rd       = head_ent.rd;
    lsq_pd       = head_ent.pd;
    lsq_br_mask  = head_ent.br_mask;
  end
endmodule

// File: rtl/mem_agu_multilane.sv
// Multi-lane load/store AGU between the MEM issue ports and the LSQ; one independent lane
// per issue port, branch resolution broadcast to all lanes.
module mem_agu_multilane
  import mem_agu_multilane_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_agu_multilane_if.slave  bus
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    agu_entry_t in_ent;

    always_comb begin
      in_ent         = '0;
      in_ent.valid   = 1'b1;
      in_ent.ps1     = bus.iss_ps1_v[l];
      in_ent.ps2     = bus.iss_ps2_v[l];
      in_ent.imm     = bus.iss_imm[l];
      in_ent.f3      = load_store_f3_t'(bus.iss_f3[l]);
      in_ent.is_str  = bus.iss_is_str[l];
      in_ent.rob_idx = bus.iss_rob_idx[l];
      in_ent.lsq_idx = bus.iss_lsq_idx[l];
      in_ent.rd      = bus.iss_rd[l];
      in_ent.pd      = bus.iss_pd[l];
      in_ent.br_mask = bus.iss_br_mask[l];
    end

    mem_agu_multilane_lane #(.DEPTH(DEPTH)) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .iss_valid    (bus.iss_valid[l]),
      .iss_ready    (bus.iss_ready[l]),
      .iss_ent      (in_ent),
      .br_valid     (bus.br_valid),
      .br_mispred   (bus.br_mispred),
      .br_idx       (bus.br_idx),
      .lsq_valid    (bus.lsq_valid[l]),
      .lsq_ready    (bus.lsq_ready[l]),
      .lsq_addr     (bus.lsq_addr[l]),
      .lsq_wmask    (bus.lsq_wmask[l]),
      .lsq_str_val  (bus.lsq_str_val[l]),
      .lsq_misalign (bus.lsq_misalign[l]),
      .lsq_f3       (bus.lsq_f3[l]),
      .lsq_is_str   (bus.lsq_is_str[l]),
      .lsq_rob_idx  (bus.lsq_rob_idx[l]),
      .lsq_lsq_idx  (bus.lsq_lsq_idx[l]),
      .lsq_rd       (bus.lsq_rd[l]),
      .lsq_pd       (bus.lsq_pd[l]),
      .lsq_br_mask  (bus.lsq_br_mask[l])
    );
  end
endmodule

// File: tb/tb_mem_agu_multilane.sv
// Random + directed bench for mem_agu_multilane against a per-lane queue model.
module tb_mem_agu_multilane;
  localparam int NL    = 2;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic        v;
    logic [31:0] ps1, ps2, imm;
    logic [2:0]  f3;
    logic        st;
    logic [4:0]  rob;
    logic [2:0]  lq;
    logic [4:0]  rd;
    logic [5:0]  pd;
    logic [1:0]  m;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  op_t  q [NL][$];

  mem_agu_multilane_if #(.NUM_LANES(NL)) bus ();
  mem_agu_multilane #(.NUM_LANES(NL), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes sets mask span, replication period and alignment requirement.
  function automatic void ref_agu(input op_t o, output logic [31:0] a, output logic [3:0] wm,
                                  output logic [31:0] d, output logic mis);
    int sz, mm;
    a  = o.ps1 + o.imm;
    sz = (o.f3[1:0] == 2'd0) ? 1 : (o.f3[1:0] == 2'd1) ? 2 : 4;
    mm = ((1 << sz) - 1) << a[1:0];
    if (sz == 4) mm = 15;
    wm = mm[3:0];
    for (int k = 0; k < 4; k++) d[8*k +: 8] = o.ps2[8*(k % sz) +: 8];
    mis = (int'(a[1:0]) % sz) != 0;
  endfunction

  task automatic idle();
    bus.iss_valid  = '0;
    bus.br_valid   = 1'b0;
    bus.br_mispred = 1'b0;
    bus.br_idx     = '0;
  endtask

  task automatic set_iss(input int l, input logic [2:0] f3, input logic st, input logic [31:0] ps1,
                         input logic [31:0] ps2, input logic [31:0] imm, input logic [1:0] m,
                         input logic [4:0] rob);
    bus.iss_valid[l]   = 1'b1;
    bus.iss_f3[l]      = f3;
    bus.iss_is_str[l]  = st;
    bus.iss_ps1_v[l]   = ps1;
    bus.iss_ps2_v[l]   = ps2;
    bus.iss_imm[l]     = imm;
    bus.iss_br_mask[l] = m;
    bus.iss_rob_idx[l] = rob;
    bus.iss_lsq_idx[l] = 3'(l + 2);
    bus.iss_rd[l]      = 5'd7;
    bus.iss_pd[l]      = 6'(rob + 9);
  endtask

  // Inputs are already driven for this cycle: check outputs, advance the model, clock once.
  task automatic step();
    bit kill, clr, rdy, pop;
    int idx;
    op_t h, n;
    logic [31:0] a, d;
    logic [3:0] wm;
    logic mis;
    #1;
    kill = bus.br_valid && bus.br_mispred;
    clr  = bus.br_valid && !bus.br_mispred;
    idx  = int'(bus.br_idx);
    for (int l = 0; l < NL; l++) begin
      for (int i = 0; i < q[l].size(); i++) begin
        h = q[l][i];
        if (kill && h.m[idx]) h.v = 1'b0;
        if (clr) h.m[idx] = 1'b0;
        q[l][i] = h;
      end
      rdy = q[l].size() < DEPTH;
      chk($sformatf("L%0d iss_ready", l), bus.iss_ready[l], rdy);
      if (q[l].size() > 0 && q[l][0].v) begin
        h = q[l][0];
        ref_agu(h, a, wm, d, mis);
        chk($sformatf("L%0d lsq_valid", l), bus.lsq_valid[l], 1);
        chk($sformatf("L%0d addr", l), bus.lsq_addr[l], a);
        chk($sformatf("L%0d wmask", l), bus.lsq_wmask[l], wm);
        chk($sformatf("L%0d str_val", l), bus.lsq_str_val[l], d);
        chk($sformatf("L%0d misalign", l), bus.lsq_misalign[l], mis);
        chk($sformatf("L%0d br_mask", l), bus.lsq_br_mask[l], h.m);
        chk($sformatf("L%0d rob", l), bus.lsq_rob_idx[l], h.rob);
        chk($sformatf("L%0d meta", l),
            {bus.lsq_f3[l], bus.lsq_is_str[l], bus.lsq_lsq_idx[l], bus.lsq_rd[l], bus.lsq_pd[l]},
            {h.f3, h.st, h.lq, h.rd, h.pd});
      end else begin
        chk($sformatf("L%0d lsq_valid", l), bus.lsq_valid[l], 0);
      end
      pop = q[l].size() > 0 && (!q[l][0].v || bus.lsq_ready[l]);
      n = '{v: 1'b1, ps1: bus.iss_ps1_v[l], ps2: bus.iss_ps2_v[l], imm: bus.iss_imm[l],
            f3: bus.iss_f3[l], st: bus.iss_is_str[l], rob: bus.iss_rob_idx[l],
            lq: bus.iss_lsq_idx[l], rd: bus.iss_rd[l], pd: bus.iss_pd[l], m: bus.iss_br_mask[l]};
      if (kill && n.m[idx]) n.v = 1'b0;
      if (clr) n.m[idx] = 1'b0;
      if (pop) void'(q[l].pop_front());
      if (bus.iss_valid[l] && rdy && n.v) q[l].push_back(n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_cycle();
    logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int l = 0; l < NL; l++) begin
      set_iss(l, f3s[$urandom_range(0, 4)], 1'($urandom), $urandom, $urandom, $urandom,
              2'($urandom), 5'($urandom));
      bus.iss_valid[l]   = ($urandom_range(0, 9) < 6);
      bus.iss_lsq_idx[l] = 3'($urandom);
      bus.iss_rd[l]      = 5'($urandom);
      bus.lsq_ready[l]   = ($urandom_range(0, 9) < 6);
    end
    bus.br_valid   = ($urandom_range(0, 3) == 0);
    bus.br_mispred = 1'($urandom);
    bus.br_idx     = 1'($urandom);
    step();
  endtask

  initial begin
    idle();
    set_iss(0, 3'b010, 1'b0, '0, '0, '0, '0, '0);
    set_iss(1, 3'b010, 1'b0, '0, '0, '0, '0, '0);
    idle();
    bus.lsq_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst lsq_valid", bus.lsq_valid, 2'b00);
    chk("rst addr", bus.lsq_addr[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw: present next cycle, aligned word
    set_iss(0, 3'b010, 1'b0, 32'h1000, 32'h0, 32'h10, 2'b00, 5'd1);
    step();
    idle(); #1;
    chk("lw vld", bus.lsq_valid[0], 1);
    chk("lw addr", bus.lsq_addr[0], 32'h1010);
    chk("lw wmask", bus.lsq_wmask[0], 4'b1111);
    chk("lw mis", bus.lsq_misalign[0], 0);
    step();

    // sb on lane 0, misaligned sh on lane 1
    set_iss(0, 3'b000, 1'b1, 32'h2003, 32'hAB, 32'h0, 2'b00, 5'd2);
    set_iss(1, 3'b001, 1'b1, 32'h2001, 32'h1234, 32'h0, 2'b00, 5'd3);
    step();
    idle(); #1;
    chk("sb wmask", bus.lsq_wmask[0], 4'b1000);
    chk("sb data", bus.lsq_str_val[0], 32'hABABABAB);
    chk("sh mis", bus.lsq_misalign[1], 1);
    step();

    // backpressure: third issue sees a full lane, then drain in order
    bus.lsq_ready = '0;
    set_iss(0, 3'b010, 1'b0, 32'h100, 32'h0, 32'h0, 2'b00, 5'd11); step();
    set_iss(0, 3'b010, 1'b0, 32'h104, 32'h0, 32'h0, 2'b00, 5'd12); step();
    set_iss(0, 3'b010, 1'b0, 32'h108, 32'h0, 32'h0, 2'b00, 5'd13); #1;
    chk("fill ready", bus.iss_ready[0], 0);
    step();
    idle(); bus.lsq_ready = '1; #1;
    chk("drain rob1", bus.lsq_rob_idx[0], 5'd11);
    step(); #1;
    chk("drain rob2", bus.lsq_rob_idx[0], 5'd12);
    step(); step();

    // mispredict kills head, younger op presented next
    bus.lsq_ready = '0;
    set_iss(0, 3'b010, 1'b0, 32'h200, 32'h0, 32'h0, 2'b01, 5'd3); step();
    set_iss(0, 3'b010, 1'b0, 32'h204, 32'h0, 32'h0, 2'b10, 5'd4); step();
    idle(); bus.br_valid = 1'b1; bus.br_mispred = 1'b1; bus.br_idx = 1'b0; #1;
    chk("sq head vld", bus.lsq_valid[0], 0);
    step();
    idle(); #1;
    chk("sq next vld", bus.lsq_valid[0], 1);
    chk("sq next rob", bus.lsq_rob_idx[0], 5'd4);
    chk("sq count1", bus.iss_ready[0], 1);
    step();
    bus.lsq_ready = '1; step(); step();

    // correct predict clears bit 1 in stored and incoming masks
    bus.lsq_ready = '0;
    set_iss(0, 3'b010, 1'b0, 32'h300, 32'h0, 32'h0, 2'b10, 5'd5); step();
    set_iss(0, 3'b010, 1'b0, 32'h304, 32'h0, 32'h0, 2'b11, 5'd6);
    bus.br_valid = 1'b1; bus.br_mispred = 1'b0; bus.br_idx = 1'b1; #1;
    chk("cp head mask", bus.lsq_br_mask[0], 2'b00);
    step();
    idle(); bus.lsq_ready = '1; #1;
    chk("cp head rob", bus.lsq_rob_idx[0], 5'd5);
    step(); #1;
    chk("cp in rob", bus.lsq_rob_idx[0], 5'd6);
    chk("cp in mask", bus.lsq_br_mask[0], 2'b01);
    step();

    repeat (300) rnd_cycle();

    // async reset with full lanes mid-handshake
    bus.lsq_ready = '0;
    for (int c = 0; c < 2; c++) begin
      set_iss(0, 3'b010, 1'b0, 32'h400, 32'h0, 32'h0, 2'b00, 5'(20 + c));
      set_iss(1, 3'b010, 1'b0, 32'h500, 32'h0, 32'h0, 2'b00, 5'(24 + c));
      step();
    end
    bus.lsq_ready = '1; bus.iss_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst vld", bus.lsq_valid, 2'b00);
    for (int l = 0; l < NL; l++) q[l].delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); #1;
    chk("post rst rdy", bus.iss_ready, 2'b11);
    chk("post rst vld", bus.lsq_valid, 2'b00);

    repeat (200) rnd_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
